// File: rtl/rx_serial_pkg.sv
// -----------------------------------------------------------------------------
// rx_serial_pkg
//   Shared definitions for the serial receiver: FSM state encoding and the
//   default frame timing/width constants used as parameter defaults.
// -----------------------------------------------------------------------------
package rx_serial_pkg;

    localparam int CLKS_PER_BIT_DEF = 8;  // clock cycles per serial bit
    localparam int DATA_W_DEF       = 9;  // payload bits per frame

    typedef enum logic [2:0] {
        IDLE,   // line idle, waiting for a falling edge
        START,  // timing to the middle of the start bit
        DATA,   // sampling payload bits, LSB first
        STOP,   // sampling the stop bit
        BREAK   // stop bit was low; wait for the line to go high again
    } state_t;

endpackage : rx_serial_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer bringing an asynchronous single-bit input into the
//   clk_i domain. Both flops reset to RESET_VAL.
//
// Ports
//   clk_i  in   sampling clock
//   rst_i  in   asynchronous active-high reset
//   d_i    in   asynchronous input
//   q_o    out  synchronized output (two cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: non-blocking assignments make both flops sample their inputs at the
    // same edge; blocking here would collapse the chain into a single flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/rx_serial.sv
// -----------------------------------------------------------------------------
// rx_serial
//   Serial frame receiver: 1 start bit (0), DATA_W data bits LSB first,
//   1 stop bit (1), no parity. The line is oversampled at CLKS_PER_BIT clocks
//   per bit and each bit is sampled near its middle.
//
// Ports
//   clk_i    in   clock, all state changes on the rising edge
//   rst_i    in   asynchronous active-high reset
//   rx_i     in   serial line, idle high, asynchronous to clk_i
//   data_o   out  last correctly framed word
//   valid_o  out  one-cycle pulse when data_o is updated
//   err_o    out  one-cycle pulse when the stop bit is sampled low
//   busy_o   out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module rx_serial
    import rx_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_W       = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W + 1);

    // Timer terminal counts: half a bit lands in the middle of the start bit,
    // whole bits from there land in the middle of every following bit.
    localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    logic rx_s;

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q,   tmr_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic                valid_q, valid_d;
    logic                err_q,   err_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

    // NOTE: the shift register and output word are reset along with the
    // control state so data_o reads a defined 0 before the first frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // NOTE: every signal gets a default before the case statement, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            START: begin
                if (tmr_q == HALF_LAST) begin
                    tmr_d = '0;
                    idx_d = '0;
                    // A line already back high mid-start-bit was a glitch.
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            DATA: begin
                if (tmr_q == BIT_LAST) begin
                    tmr_d = '0;
                    for (int i = 0; i < DATA_W; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            shift_d[i] = rx_s;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            STOP: begin
                if (tmr_q == BIT_LAST) begin
                    tmr_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            BREAK: begin
                tmr_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;
    assign busy_o  = (state_q != IDLE);

endmodule : rx_serial

// File: tb/tb_rx_serial.sv
// -----------------------------------------------------------------------------
// tb_rx_serial
//   Scoreboard bench for rx_serial. The driver serializes frames onto rx_i and
//   pushes the expected outcome (word or framing error, plus start time) into
//   a queue; an independent monitor pops one entry per valid_o/err_o pulse.
// -----------------------------------------------------------------------------
module tb_rx_serial;

    localparam int CPB = 8;
    localparam int DW  = 9;
    // Falling edge of rx_i to the output pulse, in clock cycles.
    localparam int LAT = 2 + CPB / 2 + (DW + 1) * CPB + 1;

    logic          clk   = 1'b0;
    logic          rst_i = 1'b1;
    logic          rx_i  = 1'b1;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          err_o;
    logic          busy_o;

    rx_serial #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (DW)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .rx_i    (rx_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .err_o   (err_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            is_err;
        logic [DW-1:0] data;
        int            start_cyc;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] last_good = '0;  // model of data_o
    int            n_tests   = 0;
    int            n_fail    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_latency(input int lat);
        n_tests++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles, expected %0d +/-1", lat, LAT);
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (!rst_i && (valid_o || err_o)) begin
            check("valid_err_exclusive", 32'(valid_o & err_o), 32'd0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: got valid=%0b err=%0b, expected no pulse", valid_o, err_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_is_err", 32'(err_o), 32'(mon_e.is_err));
                check("data_o", 32'(data_o), 32'(mon_e.data));
                check_latency(cyc - mon_e.start_cyc);
            end
        end
    end

    // Hold rx_i at a level for n clock cycles; always returns just after a rising edge.
    task automatic drive_bits(input logic b, input int n);
        rx_i = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Send one frame. stop_low > 0 replaces the stop bit by stop_low low cycles,
    // then checks the receiver stays busy until the line is released.
    task automatic send_frame(input logic [DW-1:0] d, input int stop_low);
        exp_t e;
        e.start_cyc = cyc;
        if (stop_low > 0) begin
            e.is_err = 1'b1;
            e.data   = last_good;
        end else begin
            e.is_err  = 1'b0;
            e.data    = d;
            last_good = d;
        end
        exp_q.push_back(e);
        drive_bits(1'b0, CPB);
        for (int i = 0; i < DW; i++) begin
            drive_bits(d[i], CPB);
        end
        if (stop_low > 0) begin
            drive_bits(1'b0, stop_low);
            check("busy_in_break", 32'(busy_o), 32'd1);
            drive_bits(1'b1, CPB);
            check("idle_after_break", 32'(busy_o), 32'd0);
        end else begin
            drive_bits(1'b1, CPB);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] abort_word;
        logic [DW-1:0] rnd_word;
        int            busy_hits;

        // Reset state, then a long idle line.
        rst_i = 1'b1;
        rx_i  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_data_o",  32'(data_o),  32'd0);
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_err_o",   32'(err_o),   32'd0);
        check("rst_busy_o",  32'(busy_o),  32'd0);
        rst_i = 1'b0;
        busy_hits = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy_o) busy_hits++;
        end
        check("idle_busy_cycles", 32'(busy_hits), 32'd0);
        check("idle_data_o", 32'(data_o), 32'd0);
        @(posedge clk);
        #1;

        // Single frame.
        send_frame(9'b100111100, 0);
        drive_bits(1'b1, 4);
        wait_drain();

        // Back-to-back frames with no idle gap.
        send_frame(9'h1FF, 0);
        send_frame(9'h001, 0);
        drive_bits(1'b1, 4);
        wait_drain();

        // Short low glitch on the idle line: rejected without a pulse.
        drive_bits(1'b0, 3);
        drive_bits(1'b1, 2 * CPB);
        check("glitch_busy", 32'(busy_o), 32'd0);
        check("glitch_data_o", 32'(data_o), 32'h001);

        // Framing error: stop bit held low for 20 cycles.
        send_frame(9'h0AA, 20);
        wait_drain();
        check("err_keeps_data_o", 32'(data_o), 32'h001);

        // Reset in the middle of data bit 4, then a clean frame.
        abort_word = 9'h0F0;
        drive_bits(1'b0, CPB);
        for (int i = 0; i < 4; i++) begin
            drive_bits(abort_word[i], CPB);
        end
        drive_bits(abort_word[4], CPB / 2);
        rst_i = 1'b1;
        drive_bits(1'b1, 3);
        rst_i     = 1'b0;
        last_good = '0;
        check("abort_data_o", 32'(data_o), 32'd0);
        check("abort_busy",   32'(busy_o), 32'd0);
        drive_bits(1'b1, 2 * CPB);
        check("abort_no_pulse_busy", 32'(busy_o), 32'd0);
        send_frame(9'h055, 0);
        drive_bits(1'b1, 4);
        wait_drain();

        // Randomized traffic: random words, random gaps (including none),
        // occasional framing errors of random length.
        for (int k = 0; k < 24; k++) begin
            rnd_word = DW'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                send_frame(rnd_word, int'($urandom_range(8, 24)));
            end else begin
                send_frame(rnd_word, 0);
            end
            drive_bits(1'b1, int'($urandom_range(0, 12)));
        end
        drive_bits(1'b1, 4);
        wait_drain();
        check("final_data_o", 32'(data_o), 32'(last_good));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rx_serial
